// File: rtl/matrix_pkg.sv
// Shared definitions for the block partitioner and the array assembler:
// word width, collect/full state type and flat-matrix indexing helpers.
package matrix_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    function automatic int idx_width(input int sp);
        if (sp > 1) begin
            return $clog2(sp);
        end else begin
            return 1;
        end
    endfunction

    function automatic int elem_lsb(input int r, input int c, input int n);
        return (r * n + c) * WORD_W;
    endfunction

endpackage

// File: rtl/array_assembler_block_scatter.sv
// Places one n_divide_ps x n_divide_ps result block at its (row, col) slot
// of the flat n x n matrix, with a per-element write-enable mask.
module block_scatter
    import matrix_pkg::*;
#(
    parameter int n           = 4,
    parameter int sqrt_p      = 2,
    parameter int n_divide_ps = 2,
    parameter int idx_w       = idx_width(sqrt_p)
) (
    input  logic [idx_w-1:0]                           i_row,
    input  logic [idx_w-1:0]                           i_col,
    input  logic [WORD_W*n_divide_ps*n_divide_ps-1:0]  i_data,
    output logic [WORD_W*n*n-1:0]                      o_wdata,
    output logic [n*n-1:0]                             o_wmask
);

    // Element (r,c) belongs to the block whose indices equal r/nd and c/nd;
    // out-of-range block indices match no element at all.
    always_comb begin
        o_wdata = '0;
        o_wmask = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                if (((r / n_divide_ps) == int'(i_row)) && ((c / n_divide_ps) == int'(i_col))) begin
                    o_wmask[r*n+c] = 1'b1;
                    o_wdata[elem_lsb(r, c, n) +: WORD_W] =
                        i_data[elem_lsb(r % n_divide_ps, c % n_divide_ps, n_divide_ps) +: WORD_W];
                end else begin
                    o_wmask[r*n+c] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/array_assembler.sv
// Gathers the sqrt_p x sqrt_p result blocks, arriving in any order, into the
// flat n x n matrix_C and hands the completed matrix over with out_valid/out_ready.
module array_assembler
    import matrix_pkg::*;
#(
    parameter int n           = 4,
    parameter int sqrt_p      = 2,
    parameter int n_divide_ps = 2,
    parameter int p           = 4,
    parameter int idx_w       = idx_width(sqrt_p)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      blk_valid,
    output logic                                      blk_ready,
    input  logic [idx_w-1:0]                          blk_row,
    input  logic [idx_w-1:0]                          blk_col,
    input  logic [WORD_W*n_divide_ps*n_divide_ps-1:0] blk_data,
    output logic [WORD_W*n*n-1:0]                     matrix_C,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$clog2(p+1)-1:0]                    blk_count,
    output logic                                      blk_err
);

    localparam int CW = $clog2(p + 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(p - 1);

    if ((n_divide_ps * sqrt_p != n) || (p != sqrt_p * sqrt_p)) begin : g_bad_cfg
        $error("array_assembler: inconsistent n/sqrt_p/n_divide_ps/p");
    end

    state_e                 r_state;
    state_e                 w_next_state;
    logic [p-1:0]           r_bitmap;
    logic [p-1:0]           w_onehot;
    logic [CW-1:0]          r_count;
    logic [WORD_W*n*n-1:0]  r_matrix;
    logic [WORD_W*n*n-1:0]  w_wdata;
    logic [WORD_W*n*n-1:0]  w_wmask_bits;
    logic [n*n-1:0]         w_wmask;
    logic                   r_err;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_dup;
    logic                   w_legal;
    logic                   w_last;
    logic                   w_release;

    block_scatter #(
        .n           (n),
        .sqrt_p      (sqrt_p),
        .n_divide_ps (n_divide_ps),
        .idx_w       (idx_w)
    ) u_scatter (
        .i_row   (blk_row),
        .i_col   (blk_col),
        .i_data  (blk_data),
        .o_wdata (w_wdata),
        .o_wmask (w_wmask)
    );

    // Decode the incoming block index into a one-hot bitmap position.
    always_comb begin
        w_onehot   = '0;
        w_in_range = (int'(blk_row) < sqrt_p) && (int'(blk_col) < sqrt_p);
        for (int b = 0; b < p; b++) begin
            if (w_in_range && (b == int'(blk_row) * sqrt_p + int'(blk_col))) begin
                w_onehot[b] = 1'b1;
            end else begin
                w_onehot[b] = 1'b0;
            end
        end
    end

    // Widen the element mask to bit granularity for the matrix merge.
    always_comb begin
        w_wmask_bits = '0;
        for (int e = 0; e < n * n; e++) begin
            w_wmask_bits[e*WORD_W +: WORD_W] = {WORD_W{w_wmask[e]}};
        end
    end

    assign w_accept  = blk_valid && blk_ready;
    assign w_dup     = |(w_onehot & r_bitmap);
    assign w_legal   = w_accept && w_in_range && !w_dup;
    assign w_last    = w_legal && (r_count == LAST_CNT);
    assign w_release = (r_state == FULL) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: fill completes the frame, consumer handshake reopens it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if (w_last) begin
                    w_next_state = FULL;
                end else begin
                    w_next_state = COLLECT;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_next_state = COLLECT;
                end else begin
                    w_next_state = FULL;
                end
            end
            default: w_next_state = COLLECT;
        endcase
    end

    // Handshake outputs, decoded from the registered state only.
    always_comb begin
        blk_ready = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                blk_ready = 1'b1;
                out_valid = 1'b0;
            end
            FULL: begin
                blk_ready = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                blk_ready = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Bitmap, count, matrix storage and the reject pulse; matrix_C is not
    // cleared on release so the old frame stays visible until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap <= '0;
            r_count  <= '0;
            r_matrix <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_release) begin
                r_bitmap <= '0;
                r_count  <= '0;
            end else if (w_legal) begin
                r_bitmap <= r_bitmap | w_onehot;
                r_count  <= r_count + ONE_CNT;
                r_matrix <= (r_matrix & ~w_wmask_bits) | (w_wdata & w_wmask_bits);
            end else begin
                r_bitmap <= r_bitmap;
                r_count  <= r_count;
            end
        end
    end

    assign matrix_C  = r_matrix;
    assign blk_count = r_count;
    assign blk_err   = r_err;

endmodule

// File: tb/tb_array_assembler.sv
// Randomised self-checking bench for array_assembler with a block-level
// matrix model; also exercises the single-block (p=1) configuration.
module tb_array_assembler;

    localparam int N  = 4;
    localparam int SP = 2;
    localparam int ND = 2;
    localparam int P  = 4;

    logic           clk;
    logic           rst_n;
    logic           blk_valid;
    logic           blk_ready;
    logic [0:0]     blk_row;
    logic [0:0]     blk_col;
    logic [127:0]   blk_data;
    logic [511:0]   matrix_C;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     blk_count;
    logic           blk_err;

    logic           d_blk_valid;
    logic           d_blk_ready;
    logic [0:0]     d_blk_row;
    logic [0:0]     d_blk_col;
    logic [127:0]   d_blk_data;
    logic [127:0]   d_matrix_C;
    logic           d_out_valid;
    logic           d_out_ready;
    logic [0:0]     d_blk_count;
    logic           d_blk_err;

    int n_checks;
    int n_fail;

    logic [31:0] exp_mat [N][N];
    bit          exp_seen [SP][SP];
    int          exp_count;
    bit          exp_full;
    bit          exp_err;

    array_assembler #(.n(N), .sqrt_p(SP), .n_divide_ps(ND), .p(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_row   (blk_row),
        .blk_col   (blk_col),
        .blk_data  (blk_data),
        .matrix_C  (matrix_C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_count (blk_count),
        .blk_err   (blk_err)
    );

    array_assembler #(.n(2), .sqrt_p(1), .n_divide_ps(2), .p(1)) dut_deg (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (d_blk_valid),
        .blk_ready (d_blk_ready),
        .blk_row   (d_blk_row),
        .blk_col   (d_blk_col),
        .blk_data  (d_blk_data),
        .matrix_C  (d_matrix_C),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .blk_count (d_blk_count),
        .blk_err   (d_blk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                f[(r*N+c)*32 +: 32] = exp_mat[r][c];
            end
        end
        return f;
    endfunction

    function automatic logic [127:0] quad_data(input int i, input int j);
        logic [127:0] d;
        for (int k = 0; k < ND; k++) begin
            for (int v = 0; v < ND; v++) begin
                d[(k*ND+v)*32 +: 32] = 32'(16 * (i*ND+k) + (j*ND+v));
            end
        end
        return d;
    endfunction

    function automatic logic [127:0] const_data(input logic [31:0] x);
        return {x, x, x, x};
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_clear_frame();
        exp_full  = 1'b0;
        exp_count = 0;
        for (int i = 0; i < SP; i++) begin
            for (int j = 0; j < SP; j++) begin
                exp_seen[i][j] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        model_clear_frame();
        exp_err = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_mat[r][c] = 32'h0;
            end
        end
    endtask

    // Present one block for exactly one clock, starting and ending on a negedge.
    task automatic send_block(input int i, input int j, input logic [127:0] d);
        blk_valid = 1'b1;
        blk_row   = 1'(i);
        blk_col   = 1'(j);
        blk_data  = d;
        exp_err   = 1'b0;
        if (!exp_full) begin
            if (i < SP && j < SP && !exp_seen[i][j]) begin
                exp_seen[i][j] = 1'b1;
                exp_count++;
                for (int k = 0; k < ND; k++) begin
                    for (int v = 0; v < ND; v++) begin
                        exp_mat[i*ND+k][j*ND+v] = d[(k*ND+v)*32 +: 32];
                    end
                end
                if (exp_count == P) exp_full = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_clear_frame();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (matrix_C !== 512'h0) begin n_fail++; $display("FAIL reset_matrix: got %h expected 0", matrix_C); end
        n_checks++;
        if (blk_count !== 3'd0 || out_valid !== 1'b0 || blk_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got count=%0d ov=%b err=%b expected 0 0 0", blk_count, out_valid, blk_err);
        end
        n_checks++;
        if (blk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", blk_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_in_order();
        for (int b = 0; b < P; b++) begin
            send_block(b / SP, b % SP, quad_data(b / SP, b % SP));
            n_checks++;
            if (blk_count !== 3'(exp_count) || out_valid !== exp_full) begin
                n_fail++; $display("FAIL inorder_step%0d: got count=%0d ov=%b expected %0d %b", b, blk_count, out_valid, exp_count, exp_full);
            end
        end
        n_checks++;
        if (matrix_C !== model_flat()) begin n_fail++; $display("FAIL inorder_matrix: got %h expected %h", matrix_C, model_flat()); end
        n_checks++;
        if (matrix_C[(3*N+2)*32 +: 32] !== 32'd50) begin n_fail++; $display("FAIL inorder_elem32: got %0d expected 50", matrix_C[(3*N+2)*32 +: 32]); end
        n_checks++;
        if (blk_ready !== 1'b0) begin n_fail++; $display("FAIL inorder_full_ready: got %b expected 0", blk_ready); end
        release_frame();
        n_checks++;
        if (out_valid !== 1'b0 || blk_count !== 3'd0 || blk_ready !== 1'b1) begin
            n_fail++; $display("FAIL inorder_release: got ov=%b count=%0d rdy=%b expected 0 0 1", out_valid, blk_count, blk_ready);
        end
    endtask

    task automatic test_out_of_order();
        int          ri [4] = '{1, 0, 1, 0};
        int          ci [4] = '{1, 0, 0, 1};
        logic [31:0] kv [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
        for (int b = 0; b < P; b++) begin
            send_block(ri[b], ci[b], const_data(kv[b]));
            n_checks++;
            if (out_valid !== exp_full || blk_count !== 3'(exp_count)) begin
                n_fail++; $display("FAIL ooo_step%0d: got ov=%b count=%0d expected %b %0d", b, out_valid, blk_count, exp_full, exp_count);
            end
        end
        n_checks++;
        if (matrix_C !== model_flat()) begin n_fail++; $display("FAIL ooo_matrix: got %h expected %h", matrix_C, model_flat()); end
        n_checks++;
        if (matrix_C[(0*N+3)*32 +: 32] !== 32'hD || matrix_C[(2*N+0)*32 +: 32] !== 32'hC) begin
            n_fail++; $display("FAIL ooo_quadrant: got %h %h expected d c", matrix_C[(0*N+3)*32 +: 32], matrix_C[(2*N+0)*32 +: 32]);
        end
        release_frame();
    endtask

    task automatic test_duplicate_and_backpressure();
        logic [511:0] held;
        send_block(0, 1, const_data(32'h11));
        n_checks++;
        if (blk_count !== 3'd1 || blk_err !== 1'b0) begin n_fail++; $display("FAIL dup_first: got count=%0d err=%b expected 1 0", blk_count, blk_err); end
        send_block(0, 1, const_data(32'h22));
        n_checks++;
        if (blk_err !== 1'b1 || blk_count !== 3'd1) begin n_fail++; $display("FAIL dup_pulse: got err=%b count=%0d expected 1 1", blk_err, blk_count); end
        @(negedge clk);
        n_checks++;
        if (blk_err !== 1'b0) begin n_fail++; $display("FAIL dup_pulse_len: got %b expected 0", blk_err); end
        n_checks++;
        if (matrix_C[(1*N+3)*32 +: 32] !== 32'h11 || matrix_C !== model_flat()) begin
            n_fail++; $display("FAIL dup_data: got %h expected 11", matrix_C[(1*N+3)*32 +: 32]);
        end
        send_block(0, 0, rand_data());
        send_block(1, 0, rand_data());
        send_block(1, 1, rand_data());
        held = model_flat();
        for (int c = 0; c < 5; c++) begin
            send_block(c % SP, (c + 1) % SP, rand_data());
            n_checks++;
            if (blk_ready !== 1'b0 || out_valid !== 1'b1 || blk_count !== 3'd4 || matrix_C !== held || blk_err !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: got rdy=%b ov=%b count=%0d err=%b expected 0 1 4 0", c, blk_ready, out_valid, blk_count, blk_err);
            end
        end
        release_frame();
        n_checks++;
        if (out_valid !== 1'b0 || blk_count !== 3'd0 || blk_ready !== 1'b1 || matrix_C !== held) begin
            n_fail++; $display("FAIL bp_release: got ov=%b count=%0d rdy=%b expected 0 0 1 with old matrix", out_valid, blk_count, blk_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_block(1, 0, rand_data());
        send_block(0, 1, rand_data());
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (matrix_C !== 512'h0 || blk_count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: got count=%0d ov=%b matrix_nonzero=%b expected 0 0 0", blk_count, out_valid, |matrix_C);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_block(1, 1, rand_data());
        send_block(0, 1, rand_data());
        send_block(0, 0, rand_data());
        send_block(1, 0, rand_data());
        n_checks++;
        if (out_valid !== 1'b1 || matrix_C !== model_flat()) begin
            n_fail++; $display("FAIL midrst_refill: got ov=%b matrix=%h expected 1 %h", out_valid, matrix_C, model_flat());
        end
        release_frame();
    endtask

    task automatic test_random_frames();
        int ord [4];
        int tmp;
        int pick;
        for (int f = 0; f < 8; f++) begin
            for (int a = 0; a < P; a++) ord[a] = a;
            for (int a = P - 1; a > 0; a--) begin
                pick = int'($urandom_range(a, 0));
                tmp = ord[a]; ord[a] = ord[pick]; ord[pick] = tmp;
            end
            for (int b = 0; b < P; b++) begin
                if (b > 0 && $urandom_range(2, 0) == 0) begin
                    pick = int'($urandom_range(b - 1, 0));
                    send_block(ord[pick] / SP, ord[pick] % SP, rand_data());
                    n_checks++;
                    if (blk_err !== exp_err || blk_count !== 3'(exp_count)) begin
                        n_fail++; $display("FAIL rand_dup f%0d: got err=%b count=%0d expected %b %0d", f, blk_err, blk_count, exp_err, exp_count);
                    end
                end
                send_block(ord[b] / SP, ord[b] % SP, rand_data());
                n_checks++;
                if (blk_err !== exp_err || blk_count !== 3'(exp_count) || out_valid !== exp_full) begin
                    n_fail++; $display("FAIL rand_step f%0d b%0d: got err=%b count=%0d ov=%b expected %b %0d %b", f, b, blk_err, blk_count, out_valid, exp_err, exp_count, exp_full);
                end
            end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            n_checks++;
            if (matrix_C !== model_flat() || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL rand_matrix f%0d: got %h expected %h", f, matrix_C, model_flat());
            end
            release_frame();
            n_checks++;
            if (blk_count !== 3'd0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rand_release f%0d: got count=%0d ov=%b expected 0 0", f, blk_count, out_valid);
            end
        end
    endtask

    task automatic test_degenerate();
        d_blk_valid = 1'b1;
        d_blk_row   = 1'b1;
        d_blk_col   = 1'b0;
        d_blk_data  = 128'hDEAD;
        @(negedge clk);
        d_blk_valid = 1'b0;
        n_checks++;
        if (d_blk_err !== 1'b1 || d_blk_count !== 1'b0 || d_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL deg_range: got err=%b count=%0d ov=%b expected 1 0 0", d_blk_err, d_blk_count, d_out_valid);
        end
        d_blk_valid = 1'b1;
        d_blk_row   = 1'b0;
        d_blk_data  = {32'h4, 32'h3, 32'h2, 32'h1};
        @(negedge clk);
        d_blk_valid = 1'b0;
        n_checks++;
        if (d_out_valid !== 1'b1 || d_blk_ready !== 1'b0 || d_blk_count !== 1'b1) begin
            n_fail++; $display("FAIL deg_full: got ov=%b rdy=%b count=%0d expected 1 0 1", d_out_valid, d_blk_ready, d_blk_count);
        end
        n_checks++;
        if (d_matrix_C !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            n_fail++; $display("FAIL deg_matrix: got %h expected 00000004000000030000000200000001", d_matrix_C);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        blk_valid   = 1'b0;
        blk_row     = 1'b0;
        blk_col     = 1'b0;
        blk_data    = '0;
        out_ready   = 1'b0;
        d_blk_valid = 1'b0;
        d_blk_row   = 1'b0;
        d_blk_col   = 1'b0;
        d_blk_data  = '0;
        d_out_ready = 1'b0;
        model_reset();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_duplicate_and_backpressure();
        test_reset_mid_frame();
        test_random_frames();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
